// File: rtl/dir_arbiter.sv
// dir_arbiter
//   Shares the single directory lookup/update port among NUM_REQ coherence
//   requesters. One transaction is in flight at a time and requesters are
//   picked round-robin. A requester may take an address lock with a lookup
//   and release it with an update to the same address. While the lock is
//   held, only the owner is served.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   rq_valid/rq_is_update/rq_lock  per-requester request, op and lock flag
//   rq_addr/rq_state/rq_presence/rq_tip  per-requester address and payload
//                                  (slice i belongs to requester i)
//   rq_ready                       one-hot accept pulse (ISSUE cycle)
//   rsp_valid, rsp_*               one-hot lookup result pulse and shared data
//   upd_done                       one-hot update-complete pulse
//   lookup_*/update_*              request side of the directory port
//   lookup_valid/lookup_*_state/update_done  response side of the directory port
//   busy                           transaction in flight
//   lock_timeout                   pulse: lock forcibly released
//   rsp_timeout                    pulse: directory did not answer in time
module dir_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned RSP_TIMEOUT  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      rq_valid,
  input  logic [NUM_REQ-1:0]      rq_is_update,
  input  logic [NUM_REQ-1:0]      rq_lock,
  input  logic [NUM_REQ*64-1:0]   rq_addr,
  input  logic [NUM_REQ*3-1:0]    rq_state,
  input  logic [NUM_REQ*2-1:0]    rq_presence,
  input  logic [NUM_REQ*2-1:0]    rq_tip,
  output logic [NUM_REQ-1:0]      rq_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [2:0]              rsp_state,
  output logic [1:0]              rsp_presence,
  output logic [1:0]              rsp_tip,
  output logic [NUM_REQ-1:0]      upd_done,
  output logic                    lookup_req,
  output logic [63:0]             lookup_addr,
  output logic                    update_req,
  output logic [63:0]             update_addr,
  output logic [2:0]              update_state,
  output logic [1:0]              update_presence,
  output logic [1:0]              update_tip_state,
  input  logic                    lookup_valid,
  input  logic [2:0]              lookup_state,
  input  logic [1:0]              lookup_presence,
  input  logic [1:0]              lookup_tip_state,
  input  logic                    update_done,
  output logic                    busy,
  output logic                    lock_timeout,
  output logic                    rsp_timeout
);

  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam int unsigned LTW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RTW = $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;

  logic [IW-1:0]   rr_q;
  logic [IW-1:0]   own_q;
  logic            op_upd_q;
  logic            op_lock_q;
  logic [63:0]     addr_q;
  logic [2:0]      st_q;
  logic [1:0]      pres_q;
  logic [1:0]      tip_q;

  logic [2:0]      res_state_q;
  logic [1:0]      res_pres_q;
  logic [1:0]      res_tip_q;

  logic            lock_held_q;
  logic [IW-1:0]   lock_owner_q;
  logic [63:0]     lock_addr_q;
  logic [LTW-1:0]  lock_timer_q;
  logic [RTW-1:0]  wait_cnt_q;

  logic [63:0]     addr_arr [NUM_REQ];
  logic [2:0]      st_arr   [NUM_REQ];
  logic [1:0]      pres_arr [NUM_REQ];
  logic [1:0]      tip_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] own_oh;
  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic               got_rsp;
  logic               lock_acquire;
  logic               lock_refresh;
  logic               lock_release;
  logic               lock_expire;
  logic               lock_active;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = rq_addr[g*64 +: 64];
    assign st_arr[g]   = rq_state[g*3 +: 3];
    assign pres_arr[g] = rq_presence[g*2 +: 2];
    assign tip_arr[g]  = rq_tip[g*2 +: 2];
  end

  function automatic logic [IW-1:0] wrap_idx(input int unsigned v);
    return IW'(v % NUM_REQ);
  endfunction

  assign own_oh  = NUM_REQ'(1) << own_q;
  assign got_rsp = op_upd_q ? update_done : lookup_valid;

  // Lock events are all resolved in the RESP cycle of the owning transaction.
  assign lock_acquire = (state_q == RESP) && !op_upd_q && op_lock_q && !lock_held_q;
  assign lock_refresh = (state_q == RESP) && !op_upd_q && op_lock_q && lock_held_q &&
                        (own_q == lock_owner_q);
  assign lock_release = (state_q == RESP) && op_upd_q && lock_held_q &&
                        (own_q == lock_owner_q) && (addr_q == lock_addr_q);
  // A refresh or a proper release in the expiry cycle wins over the timeout.
  assign lock_expire  = lock_held_q && !lock_refresh && !lock_release &&
                        (lock_timer_q == LTW'(LOCK_TIMEOUT - 1));
  // Arbitration treats an expiring lock as already gone.
  assign lock_active  = lock_held_q && !lock_expire;

  always_comb begin
    eligible = rq_valid;
    if (lock_active) begin
      eligible = rq_valid & (NUM_REQ'(1) << lock_owner_q);
    end
  end

  // First eligible requester at or after the rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!win_found && eligible[wrap_idx(32'(rr_q) + i)]) begin
        win_found = 1'b1;
        win_idx   = wrap_idx(32'(rr_q) + i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rq_ready    = '0;
    rsp_valid   = '0;
    upd_done    = '0;
    lookup_req  = 1'b0;
    update_req  = 1'b0;
    rsp_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) state_d = ISSUE;
      end
      ISSUE: begin
        rq_ready   = own_oh;
        lookup_req = !op_upd_q;
        update_req = op_upd_q;
        state_d    = WAIT;
      end
      WAIT: begin
        if (got_rsp) begin
          state_d = RESP;
        end else if (wait_cnt_q == RTW'(RSP_TIMEOUT - 1)) begin
          rsp_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      RESP: begin
        if (op_upd_q) upd_done  = own_oh;
        else          rsp_valid = own_oh;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q         <= '0;
      own_q        <= '0;
      op_upd_q     <= 1'b0;
      op_lock_q    <= 1'b0;
      addr_q       <= '0;
      st_q         <= '0;
      pres_q       <= '0;
      tip_q        <= '0;
      res_state_q  <= '0;
      res_pres_q   <= '0;
      res_tip_q    <= '0;
      wait_cnt_q   <= '0;
      lock_held_q  <= 1'b0;
      lock_owner_q <= '0;
      lock_addr_q  <= '0;
      lock_timer_q <= '0;
    end else begin
      // Request registers change only on a grant so the directory port
      // keeps its last value while idle.
      if (state_q == IDLE && win_found) begin
        own_q     <= win_idx;
        op_upd_q  <= rq_is_update[win_idx];
        op_lock_q <= rq_lock[win_idx];
        addr_q    <= addr_arr[win_idx];
        st_q      <= st_arr[win_idx];
        pres_q    <= pres_arr[win_idx];
        tip_q     <= tip_arr[win_idx];
        rr_q      <= wrap_idx(32'(win_idx) + 32'd1);
      end

      if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + RTW'(1);
      else                 wait_cnt_q <= '0;

      if (state_q == WAIT && !op_upd_q && lookup_valid) begin
        res_state_q <= lookup_state;
        res_pres_q  <= lookup_presence;
        res_tip_q   <= lookup_tip_state;
      end

      if (lock_acquire) begin
        lock_held_q  <= 1'b1;
        lock_owner_q <= own_q;
        lock_addr_q  <= addr_q;
        lock_timer_q <= '0;
      end else if (lock_refresh) begin
        lock_timer_q <= '0;
      end else if (lock_release || lock_expire) begin
        lock_held_q  <= 1'b0;
        lock_timer_q <= '0;
      end else if (lock_held_q) begin
        lock_timer_q <= lock_timer_q + LTW'(1);
      end
    end
  end

  assign lookup_addr      = addr_q;
  assign update_addr      = addr_q;
  assign update_state     = st_q;
  assign update_presence  = pres_q;
  assign update_tip_state = tip_q;
  assign rsp_state        = res_state_q;
  assign rsp_presence     = res_pres_q;
  assign rsp_tip          = res_tip_q;
  assign busy             = (state_q != IDLE);
  assign lock_timeout     = lock_expire;

endmodule

// File: tb/tb_dir_arbiter.sv
// Testbench for dir_arbiter with two requesters and a behavioural directory
// that answers two cycles after a request.
module tb_dir_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  rq_valid, rq_is_update, rq_lock;
  logic [N*64-1:0] rq_addr;
  logic [N*3-1:0]  rq_state;
  logic [N*2-1:0]  rq_presence, rq_tip;
  logic [N-1:0]  rq_ready, rsp_valid, upd_done;
  logic [2:0]    rsp_state;
  logic [1:0]    rsp_presence, rsp_tip;
  logic          lookup_req, update_req;
  logic [63:0]   lookup_addr, update_addr;
  logic [2:0]    update_state;
  logic [1:0]    update_presence, update_tip_state;
  logic          lookup_valid, update_done;
  logic [2:0]    lookup_state;
  logic [1:0]    lookup_presence, lookup_tip_state;
  logic          busy, lock_timeout, rsp_timeout;

  logic [63:0]   a_arr [N];
  logic [2:0]    s_arr [N];
  logic [1:0]    p_arr [N];
  logic [1:0]    t_arr [N];

  assign rq_addr     = {a_arr[1], a_arr[0]};
  assign rq_state    = {s_arr[1], s_arr[0]};
  assign rq_presence = {p_arr[1], p_arr[0]};
  assign rq_tip      = {t_arr[1], t_arr[0]};

  always #5 clk = ~clk;

  dir_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(64), .RSP_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_valid(rq_valid), .rq_is_update(rq_is_update), .rq_lock(rq_lock),
    .rq_addr(rq_addr), .rq_state(rq_state), .rq_presence(rq_presence), .rq_tip(rq_tip),
    .rq_ready(rq_ready), .rsp_valid(rsp_valid), .rsp_state(rsp_state),
    .rsp_presence(rsp_presence), .rsp_tip(rsp_tip), .upd_done(upd_done),
    .lookup_req(lookup_req), .lookup_addr(lookup_addr),
    .update_req(update_req), .update_addr(update_addr), .update_state(update_state),
    .update_presence(update_presence), .update_tip_state(update_tip_state),
    .lookup_valid(lookup_valid), .lookup_state(lookup_state),
    .lookup_presence(lookup_presence), .lookup_tip_state(lookup_tip_state),
    .update_done(update_done), .busy(busy), .lock_timeout(lock_timeout),
    .rsp_timeout(rsp_timeout)
  );

  // Directory: a request seen in cycle X is answered in cycle X+2.
  logic          silent = 1'b0;
  logic          s1_lk = 1'b0, s1_up = 1'b0, s2_lk = 1'b0, s2_up = 1'b0;
  logic [63:0]   s1_addr = '0;
  logic [6:0]    s1_pl = '0, s2_data = '0;
  logic [6:0]    mem [logic [63:0]];

  always @(posedge clk) begin
    s1_lk   <= lookup_req;
    s1_up   <= update_req;
    s1_addr <= update_req ? update_addr : lookup_addr;
    s1_pl   <= {update_state, update_presence, update_tip_state};
    s2_lk   <= s1_lk;
    s2_up   <= s1_up;
    if (s1_lk) s2_data <= mem.exists(s1_addr) ? mem[s1_addr] : 7'd0;
    if (s1_up && !silent) mem[s1_addr] = s1_pl;
  end

  assign lookup_valid = s2_lk & ~silent;
  assign update_done  = s2_up & ~silent;
  assign {lookup_state, lookup_presence, lookup_tip_state} = s2_data;

  typedef struct {
    bit          req;
    bit          upd;
    bit          lck;
    logic [63:0] addr;
    logic [2:0]  st;
    logic [1:0]  pr;
    logic [1:0]  tp;
    logic [6:0]  exp;   // expected {state, presence, tip} for lookups
  } vec_t;

  vec_t tbl [8];
  int   tests = 0;
  int   fails = 0;

  int   stray, gk, to_k, busy_at, ng, both;
  bit   g_who [4];
  int   g_k   [4];

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return 256'({rq_ready, rsp_valid, rsp_state, rsp_presence, rsp_tip, upd_done,
                 lookup_req, lookup_addr, update_req, update_addr, update_state,
                 update_presence, update_tip_state, busy, lock_timeout, rsp_timeout});
  endfunction

  task automatic set_req(input vec_t v);
    a_arr[v.req]        = v.addr;
    s_arr[v.req]        = v.st;
    p_arr[v.req]        = v.pr;
    t_arr[v.req]        = v.tp;
    rq_is_update[v.req] = v.upd;
    rq_lock[v.req]      = v.lck;
  endtask

  // Starts in an IDLE cycle A; expects rq_ready at A+1 and the result at A+4,
  // with the directory-side address/payload held from A+1 to A+4.
  task automatic run_txn(input vec_t v, input string tag);
    int rdy_k, rsp_k, unstable;
    logic [1:0] oh;
    rdy_k = -1; rsp_k = -1; unstable = 0;
    oh = 2'b01 << v.req;
    @(posedge clk); #1;
    set_req(v);
    rq_valid[v.req] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rdy_k < 0 && rq_ready[v.req]) begin
        rdy_k = k;
        rq_valid[v.req] = 1'b0;
        check_vec({tag, "_ready"}, 256'(rq_ready), 256'(oh));
        check_vec({tag, "_strobe"}, 256'({lookup_req, update_req}), 256'({!v.upd, v.upd}));
      end
      if (rdy_k >= 0) begin
        if (v.upd) begin
          if ({update_addr, update_state, update_presence, update_tip_state} !==
              {v.addr, v.st, v.pr, v.tp}) unstable++;
        end else if (lookup_addr !== v.addr) begin
          unstable++;
        end
      end
      if (rsp_valid != 0 || upd_done != 0) begin
        rsp_k = k;
        check_vec({tag, "_rspsel"}, 256'({rsp_valid, upd_done}),
                  v.upd ? 256'({2'b00, oh}) : 256'({oh, 2'b00}));
        if (!v.upd)
          check_vec({tag, "_data"}, 256'({rsp_state, rsp_presence, rsp_tip}), 256'(v.exp));
        break;
      end
    end
    rq_valid[v.req] = 1'b0;
    check_int({tag, "_rdy_lat"}, rdy_k, 1);
    check_int({tag, "_rsp_lat"}, rsp_k, 4);
    check_int({tag, "_port_hold"}, unstable, 0);
  endtask

  task automatic wait_idle(input string tag);
    int ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check_int({tag, "_idle"}, ok, 1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 64'h40,  3'b000, 2'b00, 2'b00, 7'b000_00_00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 64'h81,  3'b010, 2'b01, 2'b01, 7'b000_00_00};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 64'h81,  3'b000, 2'b00, 2'b00, 7'b010_01_01};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 64'h200, 3'b101, 2'b11, 2'b10, 7'b000_00_00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 64'h200, 3'b000, 2'b00, 2'b00, 7'b101_11_10};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 64'h81,  3'b011, 2'b10, 2'b00, 7'b000_00_00};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 64'h81,  3'b000, 2'b00, 2'b00, 7'b011_10_00};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 3'b000, 2'b00, 2'b00, 7'b000_00_00};

    rst_n = 1'b1;
    rq_valid = '0; rq_is_update = '0; rq_lock = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; s_arr[i] = '0; p_arr[i] = '0; t_arr[i] = '0;
    end
    #1 rst_n = 1'b0;
    #2 check_vec("reset_outs", all_outs(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("v%0d", i));

    // Both requesters held valid; last winner was 0 so the pointer sits at 1.
    @(posedge clk); #1;
    set_req('{1'b0, 1'b0, 1'b0, 64'h40,  3'b0, 2'b0, 2'b0, 7'b0});
    set_req('{1'b1, 1'b0, 1'b0, 64'h200, 3'b0, 2'b0, 2'b0, 7'b0});
    rq_valid = 2'b11;
    ng = 0; both = 0;
    for (int k = 0; k < 30 && ng < 4; k++) begin
      @(negedge clk);
      if (rq_ready == 2'b11) both++;
      if (rq_ready != 0) begin
        g_who[ng] = rq_ready[1];
        g_k[ng]   = k;
        ng++;
        if (ng == 4) rq_valid = '0;
      end
    end
    rq_valid = '0;
    check_int("rr_grants", ng, 4);
    check_vec("rr_order", 256'({g_who[0], g_who[1], g_who[2], g_who[3]}), 256'(4'b1010));
    check_int("rr_first", g_k[0], 1);
    for (int i = 1; i < 4; i++) check_int($sformatf("rr_gap%0d", i), g_k[i] - g_k[i-1], 5);
    check_int("rr_onehot", both, 0);
    wait_idle("rr");

    // Lock held by requester 0 blocks requester 1 until the matching update.
    run_txn('{1'b0, 1'b0, 1'b1, 64'h100, 3'b0, 2'b0, 2'b0, 7'b0}, "lock_acq");
    set_req('{1'b1, 1'b0, 1'b0, 64'h300, 3'b0, 2'b0, 2'b0, 7'b0});
    rq_valid[1] = 1'b1;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rq_ready != 0 || busy) stray++;
    end
    check_int("lock_block", stray, 0);
    run_txn('{1'b0, 1'b1, 1'b0, 64'h100, 3'b001, 2'b01, 2'b00, 7'b0}, "lock_rel");
    gk = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rq_ready[1]) begin
        gk = k;
        rq_valid[1] = 1'b0;
        break;
      end
    end
    rq_valid[1] = 1'b0;
    check_int("lock_next", gk, 2);
    wait_idle("lock_rel");

    // Lock left to expire: pulse 64 cycles after RESP, grant one cycle later.
    run_txn('{1'b0, 1'b0, 1'b1, 64'h500, 3'b0, 2'b0, 2'b0, 7'b0}, "lock_to");
    set_req('{1'b1, 1'b0, 1'b0, 64'h40, 3'b0, 2'b0, 2'b0, 7'b0});
    rq_valid[1] = 1'b1;
    to_k = -1; gk = -1;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (lock_timeout && to_k < 0) to_k = k;
      if (rq_ready[1]) begin
        gk = k;
        rq_valid[1] = 1'b0;
        break;
      end
    end
    rq_valid[1] = 1'b0;
    check_int("lock_to_pulse", to_k, 64);
    check_int("lock_to_grant", gk, 65);
    wait_idle("lock_to");

    // Silent directory: abort after 8 WAIT cycles.
    silent = 1'b1;
    @(posedge clk); #1;
    set_req('{1'b0, 1'b0, 1'b0, 64'h40, 3'b0, 2'b0, 2'b0, 7'b0});
    rq_valid[0] = 1'b1;
    to_k = -1; stray = 0; busy_at = -1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rq_ready[0]) rq_valid[0] = 1'b0;
      if (rsp_timeout && to_k < 0) to_k = k;
      if (rsp_valid != 0 || upd_done != 0) stray++;
      if (k == 10) busy_at = int'(busy);
    end
    rq_valid[0] = 1'b0;
    silent = 1'b0;
    check_int("rsp_to_pulse", to_k, 9);
    check_int("rsp_to_noresp", stray, 0);
    check_int("rsp_to_busy", busy_at, 0);

    // Reset asserted while waiting on the directory.
    @(posedge clk); #1;
    set_req('{1'b1, 1'b0, 1'b0, 64'h81, 3'b0, 2'b0, 2'b0, 7'b0});
    rq_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    rq_valid[1] = 1'b0;
    @(negedge clk);
    check_int("wait_busy", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1 check_vec("rst_in_wait", all_outs(), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_txn('{1'b1, 1'b0, 1'b0, 64'h81, 3'b0, 2'b0, 2'b0, 7'b011_10_00}, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dir_arbiter.md
Name: dir_arbiter

Overview:
- Shares the single directory lookup/update port among NUM_REQ coherence requesters, such as the L2 miss handler, the probe/release handler and the eviction engine.
- Serializes transactions and uses round-robin arbitration.
- Holds update payload stable for the directory's two-phase timing.
- Provides an address lock so a requester can do lookup-then-update atomically.
- Sits between the requesters and the directory; the directory accepts one request only when idle and responds two cycles after the request.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..4)
LOCK_TIMEOUT, 64, cycles a held lock survives without the owner's releasing update
RSP_TIMEOUT, 8, cycles to wait for lookup_valid/update_done before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rq_valid  in  NUM_REQ  per-requester request valid, held until rq_ready
rq_is_update  in  NUM_REQ  1=update, 0=lookup
rq_lock  in  NUM_REQ  lookup acquires address lock
rq_addr  in  NUM_REQ*64  request address, slice i = requester i
rq_state  in  NUM_REQ*3  update state (DIR_STATE_*)
rq_presence  in  NUM_REQ*2  update presence vector
rq_tip  in  NUM_REQ*2  update Tip vector
rq_ready  out  NUM_REQ  one-hot one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot lookup-result pulse
rsp_state  out  3  lookup state (shared, qualified by rsp_valid)
rsp_presence  out  2  lookup presence
rsp_tip  out  2  lookup Tip vector
upd_done  out  NUM_REQ  one-hot update-complete pulse
lookup_req  out  1  to directory
lookup_addr  out  64  to directory
update_req  out  1  to directory
update_addr  out  64  to directory
update_state  out  3  to directory
update_presence  out  2  to directory
update_tip_state  out  2  to directory
lookup_valid  in  1  from directory
lookup_state  in  3  from directory
lookup_presence  in  2  from directory
lookup_tip_state  in  2  from directory
update_done  in  1  from directory
busy  out  1  FSM not in IDLE
lock_timeout  out  1  one-cycle pulse, lock forcibly released
rsp_timeout  out  1  one-cycle pulse, directory failed to respond

Behaviour:
- Reset: clk clock; rst_n asynchronous, active-low. All outputs 0, FSM IDLE, rr pointer 0, lock cleared, all counters 0. Reset mid-transaction abandons it with no pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Eligible requesters: those with rq_valid=1. When a lock is held, only the lock owner is eligible.
  - Winner: first eligible index at or after the rr pointer, wrapping modulo NUM_REQ.
  - On a winner: latch its index, op, lock flag, addr and payload; go to ISSUE. rq_ready[winner] pulses in the ISSUE cycle.
  - rr pointer = winner+1 mod NUM_REQ.
- ISSUE (1 cycle): lookup_req=1 or update_req=1 per latched op, never both → WAIT.
- Directory-facing address/payload outputs: driven from latched registers continuously, stable from ISSUE through RESP. They hold their last value in IDLE.
- WAIT:
  - On lookup_valid (lookup op) or update_done (update op): capture result → RESP.
  - The other-type response is ignored.
  - Wait counter counts cycles in WAIT. At RSP_TIMEOUT: pulse rsp_timeout, no requester pulse → IDLE.
- RESP (1 cycle): pulse rsp_valid[owner] with registered result, or upd_done[owner] → IDLE.
- Timing: with request in IDLE cycle A, rq_ready is at A+1, directory response at A+3, rsp_valid/upd_done at A+4. IDLE is re-entered at A+5, giving one transaction per 5 cycles.
- Lock acquire/refresh:
  - Set at RESP of a lookup with rq_lock=1 and no lock held: lock_owner=winner, lock_addr=addr, lock timer=0.
  - Owner lookup with rq_lock=1 restarts the timer.
  - Owner lookup with rq_lock=0 leaves the lock unchanged.
- Lock release:
  - Cleared at RESP of an owner update whose addr==lock_addr.
  - An owner update to another addr keeps the lock.
- Lock timer: increments every cycle while a lock is held. At LOCK_TIMEOUT the lock clears and lock_timeout pulses; arbitration in the same cycle treats the lock as already clear.
- Non-owners: rq_valid stays pending, unacknowledged, while locked. No starvation once the lock clears, because of the rr rotation.
- rq_valid dropped before rq_ready: undefined, protocol violation. Requesters hold it.

Test Plan:
1. Single lookup, requester 0, addr 0x40 to a miss entry → rq_ready[0] at A+1, lookup_req 1 cycle at A+1, rsp_valid[0] at A+4 with state INVALID, presence 00.
2. Update from requester 1, addr 0x81, state 3'b010, presence 2'b01, tip 2'b01 → update_* stable A+1..A+4, upd_done[1] at A+4; a following lookup of 0x81 returns 010/01/01.
3. rq_valid on both requesters continuously → grants alternate 0,1,0,1, each 5 cycles apart, never both ready in one cycle.
4. Requester 0 locked lookup of 0x100 with requester 1 pending → requester 1 not granted; requester 0 updates 0x100 → upd_done[0], lock clears, requester 1 granted next IDLE.
5. Requester 0 locked lookup then idles, LOCK_TIMEOUT=64 → lock_timeout pulses 64 cycles after RESP, requester 1 granted next cycle.
6. Directory stubbed silent, RSP_TIMEOUT=8 → rsp_timeout pulses after 8 WAIT cycles, no rsp_valid, busy=0 afterward. Separately, assert rst_n in WAIT → all outputs 0 immediately.
